// File: rtl/timer_block_pkg.sv
// Shared constants for the register-file timer: FSM state codes, mode codes and the count type.
package timer_block_pkg;

  localparam logic [1:0] TMR_IDLE = 2'd0;
  localparam logic [1:0] TMR_RUN  = 2'd1;
  localparam logic [1:0] TMR_DONE = 2'd2;

  localparam logic TMR_ONESHOT  = 1'b0;
  localparam logic TMR_PERIODIC = 1'b1;

  typedef logic [31:0] count_t;

endpackage

// File: rtl/timer_block_if.sv
// Register-file <-> timer link: trigger/mode/terminal-count fields in, status/count/irq back.
interface timer_block_if;
  import timer_block_pkg::*;

  logic   rf_trig_start;
  logic   rf_trig_halt;
  logic   rf_mode;
  count_t rf_termcount;
  logic   ro_status;
  count_t ro_currcount;
  logic   timer_done;
  logic   timer_irq;

  modport master (
    output rf_trig_start, rf_trig_halt, rf_mode, rf_termcount,
    input  ro_status, ro_currcount, timer_done, timer_irq
  );

  modport slave (
    input  rf_trig_start, rf_trig_halt, rf_mode, rf_termcount,
    output ro_status, ro_currcount, timer_done, timer_irq
  );

endinterface

// File: rtl/timer_prescaler.sv
// Divides clk into count ticks: one tick every PRESCALE enabled cycles, restartable by clear.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? 16'd0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/timer_block.sv
// 32-bit one-shot/periodic timer driven by register-file trigger edges.
// Optional clock prescaler is built only when TIMER_PRESCALE_EN is defined.
module timer_block
  import timer_block_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  timer_block_if.slave bus
);

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("timer_block: PRESCALE must be in 1..65535");
  end

  logic [1:0] state;
  count_t     count;
  logic       mode_q;
  logic       irq_q;
  logic       start_q;
  logic       halt_q;
  logic       start_edge;
  logic       halt_edge;
  logic       running;
  logic       tick;

  assign start_edge = bus.rf_trig_start & ~start_q;
  assign halt_edge  = bus.rf_trig_halt  & ~halt_q;
  assign running    = (state == TMR_RUN);

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (running),
    .clear  (start_edge | halt_edge),
    .tick   (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // NOTE: every register here uses <= so all branches see pre-edge values of count/state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= TMR_IDLE;
      count   <= '0;
      mode_q  <= TMR_ONESHOT;
      irq_q   <= 1'b0;
      start_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      start_q <= bus.rf_trig_start;
      halt_q  <= bus.rf_trig_halt;
      irq_q   <= 1'b0;
      if (halt_edge) begin
        // Halt beats a simultaneous start; the count stays frozen for readback.
        if (running) state <= TMR_IDLE;
      end else if (start_edge) begin
        state  <= TMR_RUN;
        count  <= '0;
        mode_q <= bus.rf_mode;
      end else if (running && tick) begin
        if (count >= bus.rf_termcount) begin
          irq_q <= 1'b1;
          if (mode_q == TMR_PERIODIC) count <= '0;
          else                        state <= TMR_DONE;
        end else begin
          count <= count + 32'd1;
        end
      end
    end
  end

  assign bus.ro_status    = running;
  assign bus.timer_done   = (state == TMR_DONE);
  assign bus.ro_currcount = count;
  assign bus.timer_irq    = irq_q;

endmodule

// File: tb/tb_timer_block.sv
// Self-checking bench for timer_block: behavioural model + per-cycle compare, directed and random stimulus.
module tb_timer_block;

`ifdef TIMER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  timer_block_if bus ();

  timer_block #(.PRESCALE(PS)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int irq_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a timer is either idle, running or finished; it counts ticks since start.
  bit          m_running, m_finished, m_irq, m_periodic, prev_start, prev_halt;
  int unsigned m_count;
  int          m_cycles_since_tick;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_running = 0; m_finished = 0; m_irq = 0; m_periodic = 0;
      prev_start = 0; prev_halt = 0; m_count = 0; m_cycles_since_tick = 0;
    end else begin
      bit rise_start, rise_halt, ticked;
      rise_start = bus.rf_trig_start && !prev_start;
      rise_halt  = bus.rf_trig_halt && !prev_halt;
      prev_start = bus.rf_trig_start;
      prev_halt  = bus.rf_trig_halt;
      m_irq = 0;
      if (rise_halt) begin
        m_running = 0;
        m_cycles_since_tick = 0;
      end else if (rise_start) begin
        m_running = 1; m_finished = 0; m_count = 0;
        m_periodic = bus.rf_mode;
        m_cycles_since_tick = 0;
      end else if (m_running) begin
        m_cycles_since_tick++;
        ticked = (m_cycles_since_tick == PS);
        if (ticked) begin
          m_cycles_since_tick = 0;
          if (m_count >= bus.rf_termcount) begin
            m_irq = 1;
            if (m_periodic) m_count = 0;
            else begin m_running = 0; m_finished = 1; end
          end else begin
            m_count++;
          end
        end
      end
    end
  end

  // Single compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    check("status", 32'(bus.ro_status), 32'(m_running));
    check("count", bus.ro_currcount, m_count);
    check("done", 32'(bus.timer_done), 32'(m_finished));
    check("irq", 32'(bus.timer_irq), 32'(m_irq));
    if (bus.timer_irq) irq_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * PS) @(negedge clk);
  endtask

  task automatic start_timer(input logic mode, input logic [31:0] term);
    bus.rf_trig_start = 1'b0;
    cyc(1);
    bus.rf_mode = mode;
    bus.rf_termcount = term;
    bus.rf_trig_start = 1'b1;
    cyc(1);
  endtask

  initial begin
    int base;
    int pulses;
    bus.rf_trig_start = 1'b0;
    bus.rf_trig_halt  = 1'b0;
    bus.rf_mode       = 1'b0;
    bus.rf_termcount  = 32'd0;
    cyc(3);
    rst = 1'b1;

    // Idle after reset.
    cyc(10);
    check("idle_status", 32'(bus.ro_status), 32'd0);
    check("idle_count", bus.ro_currcount, 32'd0);
    check("idle_done", 32'(bus.timer_done), 32'd0);
    check("idle_irq_count", 32'(irq_seen), 32'd0);

    // One-shot, termcount 3.
    start_timer(1'b0, 32'd3);
    for (int i = 0; i < 4; i++) begin
      check("os_count", bus.ro_currcount, 32'(i));
      check("os_status", 32'(bus.ro_status), 32'd1);
      if (i < 3) wait_ticks(1);
    end
    wait_ticks(1);
    check("os_irq", 32'(bus.timer_irq), 32'd1);
    check("os_done", 32'(bus.timer_done), 32'd1);
    check("os_status_end", 32'(bus.ro_status), 32'd0);
    check("os_hold", bus.ro_currcount, 32'd3);
    cyc(1);
    check("os_irq_drop", 32'(bus.timer_irq), 32'd0);
    cyc(5);
    check("os_no_retrigger", 32'(bus.timer_done), 32'd1);

    // Periodic, termcount 4: period of five ticks.
    start_timer(1'b1, 32'd4);
    check("per_first", bus.ro_currcount, 32'd0);
    pulses = 0;
    for (int t = 1; t <= 20; t++) begin
      for (int c = 0; c < PS; c++) begin
        @(negedge clk);
        if (bus.timer_irq) pulses++;
      end
      check("per_count", bus.ro_currcount, 32'(t % 5));
    end
    check("per_pulses", 32'(pulses), 32'd4);

    // One-shot, termcount 100, halted at 37.
    start_timer(1'b0, 32'd100);
    wait_ticks(37);
    check("halt_pre", bus.ro_currcount, 32'd37);
    bus.rf_trig_halt = 1'b1;
    cyc(1);
    check("halt_status", 32'(bus.ro_status), 32'd0);
    check("halt_frozen", bus.ro_currcount, 32'd37);
    cyc(4);
    check("halt_still", bus.ro_currcount, 32'd37);
    bus.rf_trig_halt = 1'b0;
    start_timer(1'b0, 32'd100);
    check("restart_zero", bus.ro_currcount, 32'd0);
    check("restart_status", 32'(bus.ro_status), 32'd1);

    // Halt back to idle, then start and halt together.
    bus.rf_trig_halt = 1'b1;
    cyc(1);
    bus.rf_trig_halt = 1'b0;
    bus.rf_trig_start = 1'b0;
    cyc(1);
    bus.rf_trig_halt = 1'b1;
    bus.rf_trig_start = 1'b1;
    cyc(2);
    check("both_idle", 32'(bus.ro_status), 32'd0);
    bus.rf_trig_halt = 1'b0;

    // Termcount lowered below the running count.
    start_timer(1'b0, 32'd50);
    wait_ticks(10);
    check("lower_pre", bus.ro_currcount, 32'd10);
    bus.rf_termcount = 32'd5;
    wait_ticks(1);
    check("lower_irq", 32'(bus.timer_irq), 32'd1);
    check("lower_done", 32'(bus.timer_done), 32'd1);
    check("lower_hold", bus.ro_currcount, 32'd10);

    // Asynchronous reset mid-count.
    start_timer(1'b1, 32'd1000);
    wait_ticks(20);
    check("rst_pre", bus.ro_currcount, 32'd20);
    base = irq_seen;
    #2 rst = 1'b0;
    #1;
    check("rst_count", bus.ro_currcount, 32'd0);
    check("rst_status", 32'(bus.ro_status), 32'd0);
    check("rst_done", 32'(bus.timer_done), 32'd0);
    check("rst_irq", 32'(bus.timer_irq), 32'd0);
    cyc(2);
    bus.rf_trig_start = 1'b0;
    rst = 1'b1;
    cyc(3);
    check("rst_no_irq", 32'(irq_seen), 32'(base));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.rf_trig_start = ~bus.rf_trig_start;
      if ($urandom_range(0, 11) == 0) bus.rf_trig_halt = ~bus.rf_trig_halt;
      if ($urandom_range(0, 3) == 0) bus.rf_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.rf_termcount = 32'($urandom_range(0, 12));
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
